// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between the fetch stage and memory.
`default_nettype none

interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: instruction fetch with 1-entry hold buffer, flush/redirect and IF/ID register.
// Optional macro IF_STAGE_CNT_EN adds fetch/drop counters. Rev 1.0
`default_nettype none

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        i_pc_write,
   input  wire logic        i_ifid_write,
   input  wire logic        i_ifid_flush,
   input  wire logic [31:0] i_branch_target,
   if_stage_if.master       imem,
   output logic [31:0]      o_ifid_pc,
   output logic [31:0]      o_ifid_inst,
   output logic             o_ifid_valid
`ifdef IF_STAGE_CNT_EN
  ,output logic [31:0]      o_fetch_cnt,
   output logic [31:0]      o_drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_redirect, w_redirect_nxt;
   logic [31:0] r_hold_inst;
   logic [31:0] w_ifid_inst_nxt;
   logic        w_hold_load, w_ifid_load, w_drop;
   logic        w_req, w_ack, w_stall;
   logic [31:0] w_tgt;

   assign w_req   = (r_state == ST_REQ) || (r_state == ST_DROP);
   // An ack outside an active request is a stray strobe and is ignored.
   assign w_ack   = imem.imem_ack && w_req;
   assign w_stall = !i_pc_write || !i_ifid_write;
   assign w_tgt   = i_branch_target & ~32'h0000_0003;

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_addr;

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_redirect_nxt  = r_redirect;
      w_hold_load     = 1'b0;
      w_ifid_load     = 1'b0;
      w_ifid_inst_nxt = imem.imem_rdata;
      w_drop          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_REQ;
            if (i_ifid_flush) w_addr_nxt = w_tgt;
         end
         ST_REQ: begin
            if (i_ifid_flush) begin
               if (w_ack) begin
                  w_addr_nxt = w_tgt;
                  w_drop     = 1'b1;
               end else begin
                  w_state_nxt    = ST_DROP;
                  w_redirect_nxt = w_tgt;
               end
            end else if (w_ack) begin
               if (w_stall) begin
                  w_state_nxt = ST_HOLD;
                  w_hold_load = 1'b1;
               end else begin
                  w_ifid_load = 1'b1;
                  w_addr_nxt  = r_addr + 32'd4;
               end
            end
         end
         ST_HOLD: begin
            if (i_ifid_flush) begin
               w_state_nxt = ST_REQ;
               w_addr_nxt  = w_tgt;
               w_drop      = 1'b1;
            end else if (!w_stall) begin
               w_state_nxt     = ST_REQ;
               w_ifid_load     = 1'b1;
               w_ifid_inst_nxt = r_hold_inst;
               w_addr_nxt      = r_addr + 32'd4;
            end
         end
         ST_DROP: begin
            if (w_ack) begin
               w_state_nxt = ST_REQ;
               w_drop      = 1'b1;
               w_addr_nxt  = i_ifid_flush ? w_tgt : r_redirect;
            end else if (i_ifid_flush) begin
               w_redirect_nxt = w_tgt;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // The request address doubles as the buffered PC while in HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= RESET_PC;
         r_redirect   <= RESET_PC;
         r_hold_inst  <= 32'd0;
         o_ifid_pc    <= 32'd0;
         o_ifid_inst  <= NOP_INST;
         o_ifid_valid <= 1'b0;
      end else begin
         r_addr     <= w_addr_nxt;
         r_redirect <= w_redirect_nxt;
         if (w_hold_load) r_hold_inst <= imem.imem_rdata;
         if (i_ifid_flush) begin
            o_ifid_pc    <= 32'd0;
            o_ifid_inst  <= NOP_INST;
            o_ifid_valid <= 1'b0;
         end else if (w_ifid_load) begin
            o_ifid_pc    <= r_addr;
            o_ifid_inst  <= w_ifid_inst_nxt;
            o_ifid_valid <= 1'b1;
         end
      end
   end

`ifdef IF_STAGE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_fetch_cnt <= 32'd0;
         o_drop_cnt  <= 32'd0;
      end else begin
         if (w_ifid_load && !i_ifid_flush) o_fetch_cnt <= o_fetch_cnt + 32'd1;
         if (w_drop)                       o_drop_cnt  <= o_drop_cnt + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire
